// File: rtl/fenotipo_pkg.sv
// Shared types and layout helpers for the serial phenotype evaluator.
// Field offsets describe where each gene lives inside the flat chromosome.
package fenotipo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EVAL = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic int calc_bits_sel(input int in_n, input int nodes);
        return $clog2(in_n + nodes);
    endfunction

    function automatic int calc_chrom_w(input int nodes, input int k, input int out_n, input int bits_sel);
        return nodes * (2 ** k) + out_n * bits_sel + nodes * k * bits_sel;
    endfunction

    function automatic int calc_nwords(input int chrom_w, input int word);
        return (chrom_w + word - 1) / word;
    endfunction

    function automatic int calc_fit_w(input int out_n, input int in_n);
        return $clog2(out_n * (2 ** in_n) + 1);
    endfunction

    function automatic int lut_off(input int n, input int k);
        return n * (2 ** k);
    endfunction

    function automatic int out_sel_off(input int o, input int nodes, input int k, input int bits_sel);
        return nodes * (2 ** k) + o * bits_sel;
    endfunction

    function automatic int in_sel_off(input int n, input int b, input int nodes, input int k,
                                      input int out_n, input int bits_sel);
        return nodes * (2 ** k) + out_n * bits_sel + (n * k + b) * bits_sel;
    endfunction

endpackage

// File: rtl/fenotipo_serial_eval_cgp_column_eval.sv
// Combinational evaluation of one grid column: ROWS LUT nodes fed from the
// primary inputs and the registered node values of earlier columns.
module cgp_column_eval
    import fenotipo_pkg::*;
#(
    parameter int IN   = 4,
    parameter int OUT  = 2,
    parameter int ROWS = 2,
    parameter int COLS = 3,
    parameter int K    = 4
) (
    input  logic [calc_chrom_w(ROWS*COLS, K, OUT, calc_bits_sel(IN, ROWS*COLS))-1:0] chrom,
    input  logic [IN+ROWS*COLS-1:0]                                                  vals,
    input  logic [$clog2(COLS+1)-1:0]                                                col,
    output logic [ROWS-1:0]                                                          col_out
);

    localparam int NODES    = ROWS * COLS;
    localparam int BITS_SEL = calc_bits_sel(IN, NODES);
    localparam int LUT_N    = 2 ** K;

    logic [BITS_SEL-1:0] sel_s;
    logic [K-1:0]        addr_s;
    logic [LUT_N-1:0]    lut_s;
    int                  node_s;

    // Selectors pointing at the same or a later column read 0 so the grid stays feed-forward.
    always_comb begin
        col_out = '0;
        sel_s   = '0;
        addr_s  = '0;
        lut_s   = '0;
        node_s  = 0;
        if (int'(col) < COLS) begin
            for (int r = 0; r < ROWS; r++) begin
                node_s = int'(col) * ROWS + r;
                addr_s = '0;
                for (int b = 0; b < K; b++) begin
                    sel_s = chrom[in_sel_off(node_s, b, NODES, K, OUT, BITS_SEL) +: BITS_SEL];
                    if (int'(sel_s) < IN + int'(col) * ROWS) begin
                        addr_s[b] = vals[sel_s];
                    end else begin
                        addr_s[b] = 1'b0;
                    end
                end
                lut_s      = chrom[lut_off(node_s, K) +: LUT_N];
                col_out[r] = lut_s[addr_s];
            end
        end else begin
            col_out = '0;
        end
    end

endmodule

// File: rtl/fenotipo_serial_eval.sv
// Phenotype evaluator top: word-serial chromosome load, column-per-cycle grid
// evaluation over every input vector, and fitness accumulation against a target.
module fenotipo_serial_eval
    import fenotipo_pkg::*;
#(
    parameter int IN   = 4,
    parameter int OUT  = 2,
    parameter int ROWS = 2,
    parameter int COLS = 3,
    parameter int K    = 4,
    parameter int WORD = 8
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      start,
    input  logic [WORD-1:0]                           load_data,
    input  logic                                      load_valid,
    output logic                                      load_ready,
    input  logic [OUT*(2**IN)-1:0]                    target,
    output logic                                      busy,
    output logic                                      done,
    output logic [calc_fit_w(OUT, IN)-1:0]            fitness
);

    localparam int NODES    = ROWS * COLS;
    localparam int VECS     = 2 ** IN;
    localparam int BITS_SEL = calc_bits_sel(IN, NODES);
    localparam int CHROM_W  = calc_chrom_w(NODES, K, OUT, BITS_SEL);
    localparam int NWORDS   = calc_nwords(CHROM_W, WORD);
    localparam int FIT_W    = calc_fit_w(OUT, IN);
    localparam int WCNT_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int COL_W    = $clog2(COLS + 1);

    state_e              state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                load_ready_q, load_ready_d;
    logic [FIT_W-1:0]    fitness_q, fitness_d;
    logic [FIT_W-1:0]    acc_q, acc_d, acc_new_s;
    logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [CHROM_W-1:0]  chrom_q, chrom_d;
    logic [IN-1:0]       vec_q, vec_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [NODES-1:0]    node_q, node_d;
    logic [IN+NODES-1:0] vals_s;
    logic [ROWS-1:0]     col_out_s;
    logic [BITS_SEL-1:0] osel_s;
    logic                obit_s;
    int                  bitpos_s;

    assign vals_s = {node_q, vec_q};

    cgp_column_eval #(
        .IN   (IN),
        .OUT  (OUT),
        .ROWS (ROWS),
        .COLS (COLS),
        .K    (K)
    ) u_col (
        .chrom   (chrom_q),
        .vals    (vals_s),
        .col     (col_q),
        .col_out (col_out_s)
    );

    // Compare cycle: count output bits that agree with the target for the current vector.
    always_comb begin
        acc_new_s = acc_q;
        osel_s    = '0;
        obit_s    = 1'b0;
        for (int o = 0; o < OUT; o++) begin
            osel_s = chrom_q[out_sel_off(o, NODES, K, BITS_SEL) +: BITS_SEL];
            if (int'(osel_s) < IN + NODES) begin
                obit_s = vals_s[osel_s];
            end else begin
                obit_s = 1'b0;
            end
            if (obit_s == target[o * VECS + int'(vec_q)]) begin
                acc_new_s = acc_new_s + FIT_W'(1'b1);
            end else begin
                acc_new_s = acc_new_s;
            end
        end
    end

    // Sequencer: load words, sweep columns then compare for each vector, publish fitness.
    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        load_ready_d = load_ready_q;
        fitness_d    = fitness_q;
        acc_d        = acc_q;
        word_cnt_d   = word_cnt_q;
        chrom_d      = chrom_q;
        vec_d        = vec_q;
        col_d        = col_q;
        node_d       = node_q;
        bitpos_s     = 0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_LOAD;
                    busy_d       = 1'b1;
                    load_ready_d = 1'b1;
                    word_cnt_d   = '0;
                    acc_d        = '0;
                    vec_d        = '0;
                    col_d        = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (load_valid && load_ready_q) begin
                    // Bits past the chromosome end in the final word are dropped.
                    for (int i = 0; i < WORD; i++) begin
                        bitpos_s = int'(word_cnt_q) * WORD + i;
                        if (bitpos_s < CHROM_W) begin
                            chrom_d[bitpos_s] = load_data[i];
                        end else begin
                            chrom_d = chrom_d;
                        end
                    end
                    if (word_cnt_q == WCNT_W'(NWORDS - 1)) begin
                        state_d      = ST_EVAL;
                        load_ready_d = 1'b0;
                        word_cnt_d   = '0;
                    end else begin
                        word_cnt_d = word_cnt_q + WCNT_W'(1'b1);
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_EVAL: begin
                if (int'(col_q) < COLS) begin
                    for (int r = 0; r < ROWS; r++) begin
                        node_d[int'(col_q) * ROWS + r] = col_out_s[r];
                    end
                    col_d = col_q + COL_W'(1'b1);
                end else begin
                    acc_d = acc_new_s;
                    col_d = '0;
                    vec_d = vec_q + IN'(1'b1);
                    if (vec_q == {IN{1'b1}}) begin
                        state_d   = ST_DONE;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        fitness_d = acc_new_s;
                    end else begin
                        state_d = ST_EVAL;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d      = ST_IDLE;
                busy_d       = 1'b0;
                load_ready_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            load_ready_q <= 1'b0;
            fitness_q    <= '0;
            acc_q        <= '0;
            word_cnt_q   <= '0;
            chrom_q      <= '0;
            vec_q        <= '0;
            col_q        <= '0;
            node_q       <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            load_ready_q <= load_ready_d;
            fitness_q    <= fitness_d;
            acc_q        <= acc_d;
            word_cnt_q   <= word_cnt_d;
            chrom_q      <= chrom_d;
            vec_q        <= vec_d;
            col_q        <= col_d;
            node_q       <= node_d;
        end
    end

    assign load_ready = load_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fitness    = fitness_q;

endmodule

// File: tb/tb_fenotipo_serial_eval.sv
// Directed bench for fenotipo_serial_eval at default parameters (200-bit
// chromosome in 25 bytes, 16 vectors, fitness out of 32).
module tb_fenotipo_serial_eval;

    localparam int CW = 200;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  load_data;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] target;
    logic        busy;
    logic        done;
    logic [5:0]  fitness;

    int checks;
    int failures;

    fenotipo_serial_eval dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .target     (target),
        .busy       (busy),
        .done       (done),
        .fitness    (fitness)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Layout: LUTs at n*16, out selectors at 96+o*4, node input selectors at 104+(n*4+b)*4.
    function automatic logic [CW-1:0] mk(input logic [15:0] lut, input logic [3:0] osel, input logic [3:0] s00);
        logic [CW-1:0] c;
        c = '0;
        for (int n = 0; n < 6; n++) c[n*16 +: 16] = lut;
        for (int o = 0; o < 2; o++) c[96 + o*4 +: 4] = osel;
        c[104 +: 4] = s00;
        return c;
    endfunction

    // Cycle 0 is the first LOAD cycle; with back-to-back words done appears in cycle 89.
    task automatic run_case(input string tag, input logic [CW-1:0] ch, input logic [31:0] tg,
                            input bit toggle, input bit extra_start, input int abort_at,
                            input int exp_fit, input int exp_lat);
        int cyc, wi, done_cnt, done_cyc;
        target = tg;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0; wi = 0; done_cnt = 0; done_cyc = -1;
        chk({tag, "_busy0"}, {31'd0, busy}, 32'd1);
        chk({tag, "_ready0"}, {31'd0, load_ready}, 32'd1);
        while (cyc < 400 && (done_cyc < 0 || cyc < done_cyc + 4)) begin
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (abort_at >= 0 && cyc == abort_at) break;
            start = (extra_start && cyc == 50);
            if (load_ready && wi < 25) begin
                load_valid = toggle ? (cyc % 2 == 0) : 1'b1;
                load_data  = ch[wi*8 +: 8];
                if (load_valid) wi++;
            end else begin
                load_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        load_valid = 1'b0;
        if (abort_at >= 0) begin
            rst_n = 1'b0;
            #1;
            chk({tag, "_rst_busy"}, {31'd0, busy}, 32'd0);
            chk({tag, "_rst_done"}, {31'd0, done}, 32'd0);
            chk({tag, "_rst_ready"}, {31'd0, load_ready}, 32'd0);
            chk({tag, "_rst_fitness"}, {26'd0, fitness}, 32'd0);
            chk({tag, "_no_done"}, done_cnt, 32'd0);
            @(negedge clk); rst_n = 1'b1;
            @(negedge clk);
        end else begin
            chk({tag, "_done_count"}, done_cnt, 32'd1);
            chk({tag, "_latency"}, done_cyc, exp_lat);
            chk({tag, "_fitness"}, {26'd0, fitness}, exp_fit);
            chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        start = 1'b0;
        load_data = 8'd0;
        load_valid = 1'b0;
        target = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_ready", {31'd0, load_ready}, 32'd0);
        chk("reset_fitness", {26'd0, fitness}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Every node and output follows input bit 0, matching an AAAA target everywhere.
        run_case("all_match", mk(16'hAAAA, 4'd0, 4'd0), {16'hAAAA, 16'hAAAA}, 1'b0, 1'b0, -1, 32, 89);
        run_case("none_match", mk(16'hAAAA, 4'd0, 4'd0), {16'h5555, 16'h5555}, 1'b0, 1'b0, -1, 0, 89);
        // Both outputs see a constant-0 node: out0 matches upper 8 vectors, out1 matches all 16.
        run_case("const_zero", mk(16'h0000, 4'd4, 4'd0), {16'h0000, 16'h00FF}, 1'b0, 1'b0, -1, 24, 89);
        // Words on even cycles only: last word accepted in cycle 48, so done in cycle 113.
        run_case("stall_restart", mk(16'hAAAA, 4'd0, 4'd0), {16'hAAAA, 16'hAAAA}, 1'b1, 1'b1, -1, 32, 113);
        // Forward selector for address bit 0 reads 0, so AAAA yields 0 on every vector.
        run_case("fwd_ref", mk(16'hAAAA, 4'd4, 4'd6), 32'h0000_0000, 1'b0, 1'b0, -1, 32, 89);
        run_case("abort", mk(16'hAAAA, 4'd0, 4'd0), {16'hAAAA, 16'hAAAA}, 1'b0, 1'b0, 55, 0, 0);
        run_case("after_abort", mk(16'h0000, 4'd4, 4'd0), {16'h0000, 16'h00FF}, 1'b0, 1'b0, -1, 24, 89);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
